// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the pixel fetcher always wins, and CPU operations queue
// in an in-order command FIFO that drains into idle slots.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              starve_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic              fifo_we    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              rd_out;
  logic              push, pop;
  logic [CW-1:0]     wait_cnt, wait_next;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head_we    = fifo_we[rd_ptr[IW-1:0]];
  assign head_addr  = fifo_addr[rd_ptr[IW-1:0]];
  assign head_wdata = fifo_wdata[rd_ptr[IW-1:0]];

  // The returning read frees the single outstanding-read slot in its own cycle.
  assign cpu_ready = !fifo_full && (!rd_out || cpu_rvalid);
  assign push      = cpu_req && cpu_ready;
  assign pop       = resetn && !pix_req && !fifo_empty;

  assign pix_data  = mem_rdata;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pix_addr;
    mem_wdata = head_wdata;
    if (resetn && pix_req) begin
      mem_en = 1'b1;
    end else if (pop) begin
      mem_en   = 1'b1;
      mem_we   = head_we;
      mem_addr = head_addr;
    end
  end

  always_comb begin
    wait_next = wait_cnt;
    if (pop)
      wait_next = '0;
    else if (!fifo_empty && wait_cnt != WAIT_LIMIT)
      wait_next = wait_cnt + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_we[wr_ptr[IW-1:0]]    <= cpu_we;
      fifo_addr[wr_ptr[IW-1:0]]  <= cpu_addr;
      fifo_wdata[wr_ptr[IW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_out     <= 1'b0;
      pix_valid  <= 1'b0;
      cpu_rvalid <= 1'b0;
      wait_cnt   <= '0;
      starve_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !cpu_we)
        rd_out <= 1'b1;
      else if (cpu_rvalid)
        rd_out <= 1'b0;
      pix_valid  <= pix_req;
      cpu_rvalid <= pop && !head_we;
      wait_cnt   <= wait_next;
      if (wait_next == WAIT_LIMIT)
        starve_err <= 1'b1;
    end
  end

endmodule
